// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a req/ack
// handshake and holds it for decode until consumed or redirected.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nRst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] w_target;

    assign w_target = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  w_next_state = FETCH;
            FETCH: begin
                if (imem_ack && !redirect_valid) begin
                    w_next_state = VALID;
                end else if (!imem_ack && redirect_valid) begin
                    w_next_state = FLUSH;
                end
            end
            // The in-flight request must complete before the redirected fetch starts.
            FLUSH: begin
                if (imem_ack) begin
                    w_next_state = FETCH;
                end
            end
            VALID: begin
                if (redirect_valid || !stall) begin
                    w_next_state = FETCH;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == FETCH) || (r_state == FLUSH);
        instr_valid = (r_state == VALID);
        imem_addr   = r_pc;
        instruction = r_instr;
        instr_pc    = r_instr_pc;
        pc_plus4    = r_instr_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_pc       <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= RESET_PC;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            r_pc <= w_target;
                        end else begin
                            r_instr    <= imem_rdata;
                            r_instr_pc <= r_pc;
                        end
                    end else if (redirect_valid) begin
                        r_pend_pc <= w_target;
                    end
                end
                // Latest redirect wins, even one arriving with the flushed ack.
                FLUSH: begin
                    if (imem_ack) begin
                        r_pc <= redirect_valid ? w_target : r_pend_pc;
                    end else if (redirect_valid) begin
                        r_pend_pc <= w_target;
                    end
                end
                VALID: begin
                    if (redirect_valid) begin
                        r_instr <= NOP_INSTR;
                        r_pc    <= w_target;
                    end else if (!stall) begin
                        r_instr <= NOP_INSTR;
                        r_pc    <= r_pc + 32'd4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected request addresses and decoded words are
// queued by the directed stimulus and popped by independent monitors.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRst, imem_req, imem_ack, stall, redirect_valid, instr_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, instr_pc, pc_plus4;

    logic        nRst2, req2, ack2, stall2, rv2, valid2;
    logic [31:0] addr2, rdata2, rpc2, instr2, ipc2, pp4_2;

    fetch_unit dut (
        .clk(clk), .nRst(nRst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
        .pc_plus4(pc_plus4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .nRst(nRst2), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .stall(stall2),
        .redirect_valid(rv2), .redirect_pc(rpc2),
        .instr_valid(valid2), .instruction(instr2), .instr_pc(ipc2),
        .pc_plus4(pp4_2)
    );

    // Memory model: zero-wait unless gated off, or the address matches dly_addr (ack on 4th cycle).
    logic        ack_en;
    logic [31:0] dly_addr;
    int          wcnt = 0;
    assign imem_ack   = imem_req && ack_en && ((imem_addr != dly_addr) || (wcnt >= 3));
    assign imem_rdata = (imem_addr == 32'h4) ? 32'h0050_0093 : (32'hA000_0000 | imem_addr);
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    assign ack2   = req2;
    assign rdata2 = 32'h00A0_0113;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %08h with nothing expected", name, act);
    endtask

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_ins_q[$];
    logic [63:0] e_ins;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (imem_req && imem_ack) begin
            if (exp_addr_q.size() == 0) fail_now("unexpected_req", imem_addr);
            else chk("req_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (instr_valid && !prev_valid) begin
            if (exp_ins_q.size() == 0) begin
                fail_now("unexpected_instr", instr_pc);
            end else begin
                e_ins = exp_ins_q.pop_front();
                chk("instr_pc", instr_pc, e_ins[63:32]);
                chk("instruction", instruction, e_ins[31:0]);
                chk("pc_plus4", pc_plus4, e_ins[63:32] + 32'd4);
            end
        end
        prev_valid <= instr_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_pc(input logic [31:0] pc);
        int k = 0;
        while (!(instr_valid && instr_pc == pc) && k < 50) begin
            tick();
            k++;
        end
        chk("reach_valid_pc", instr_valid ? instr_pc : 32'hDEAD_DEAD, pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ack_en = 1'b1; dly_addr = 32'hFFFF_FFF0;
        nRst2 = 1'b0; stall2 = 1'b0; rv2 = 1'b0; rpc2 = 32'h0;

        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_ins_q.push_back({32'h0, 32'hA000_0000});
        exp_ins_q.push_back({32'h4, 32'h0050_0093});
        exp_ins_q.push_back({32'h8, 32'hA000_0008});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instruction", instruction, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);

        // Zero-wait fetch of 0x0, 0x4, 0x8
        nRst = 1'b1;
        chk("req_at_release", imem_req, 0);
        tick();
        chk("req_one_after_release", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        wait_valid_pc(32'h8);

        // Stall held in VALID at 0x8
        stall = 1'b1;
        repeat (5) begin
            tick();
            chk("stall_instr_pc", instr_pc, 32'h8);
            chk("stall_instruction", instruction, 32'hA000_0008);
            chk("stall_valid", instr_valid, 1);
            chk("stall_no_req", imem_req, 0);
        end
        exp_addr_q.push_back(32'hC);
        exp_ins_q.push_back({32'hC, 32'hA000_000C});
        stall = 1'b0;
        tick();
        chk("after_stall_addr", imem_addr, 32'hC);
        chk("after_stall_req", imem_req, 1);
        wait_valid_pc(32'hC);

        // Redirect to unaligned 0x103 together with stall
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        exp_addr_q.push_back(32'h100);
        exp_ins_q.push_back({32'h100, 32'hA000_0100});
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid_drop", instr_valid, 0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_nop", instruction, 32'h0000_0013);
        wait_valid_pc(32'h100);

        // Delayed ack at 0x4
        dly_addr = 32'h4;
        redirect_valid = 1'b1;
        redirect_pc = 32'h4;
        exp_addr_q.push_back(32'h4);
        exp_ins_q.push_back({32'h4, 32'h0050_0093});
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, 32'h4);
            if (i < 3) tick();
        end
        tick();
        chk("delayed_valid", instr_valid, 1);
        chk("delayed_instruction", instruction, 32'h0050_0093);

        // Two redirects while the request to 0x10 is outstanding
        ack_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        exp_addr_q.push_back(32'h10);
        exp_addr_q.push_back(32'h80);
        exp_ins_q.push_back({32'h80, 32'hA000_0080});
        tick();
        redirect_valid = 1'b0;
        chk("out_req", imem_req, 1);
        chk("out_addr0", imem_addr, 32'h10);
        tick();
        chk("out_addr1", imem_addr, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        chk("flush_addr0", imem_addr, 32'h10);
        chk("flush_valid", instr_valid, 0);
        redirect_pc = 32'h80;
        tick();
        chk("flush_addr1", imem_addr, 32'h10);
        redirect_valid = 1'b0;
        ack_en = 1'b1;
        tick();
        chk("post_flush_addr", imem_addr, 32'h80);
        chk("post_flush_req", imem_req, 1);
        wait_valid_pc(32'h80);

        repeat (3) tick();
        chk("addr_q_drained", exp_addr_q.size(), 0);
        chk("instr_q_drained", exp_ins_q.size(), 0);

        // PC wrap with RESET_PC = 0xFFFFFFFC, then reset mid-FETCH
        nRst2 = 1'b1;
        chk("wrap_rst_req", req2, 0);
        chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
        chk("wrap_rst_pp4", pp4_2, 32'h0);
        tick();
        chk("wrap_req0", req2, 1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        tick();
        chk("wrap_valid", valid2, 1);
        chk("wrap_instr_pc", ipc2, 32'hFFFF_FFFC);
        chk("wrap_instruction", instr2, 32'h00A0_0113);
        chk("wrap_pc_plus4", pp4_2, 32'h0);
        tick();
        chk("wrap_req1", req2, 1);
        chk("wrap_addr1", addr2, 32'h0);
        #2;
        nRst2 = 1'b0;
        #1;
        chk("midreset_req", req2, 0);
        chk("midreset_instruction", instr2, 32'h0000_0013);
        chk("midreset_valid", valid2, 0);
        chk("midreset_addr", addr2, 32'hFFFF_FFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
